// File: rtl/diff_backprop_pipe.sv
// Elastic pipeline for the backprop bundle, carried from the differentiation stage to weight update.
// Latency: `stages` cycles from accept to out_valid; the payload passes through unmodified.
// Backpressure: valid/ready, empty stages collapse, and in_ready drops only when every stage is full and out_ready=0.
// Optional stall statistics (stall_count / stall_clear) are enabled by DIFF_BACKPROP_PIPE_STALL_STATS_EN.
module diff_backprop_pipe #(
    parameter int size       = 3,
    parameter int data_size  = 16,
    parameter int index_size = 32,
    parameter int stages     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [index_size-1:0]          w_layer_index,
    input  logic [index_size-1:0]          w_row_index,
    input  logic                           backprop_cost,
    input  logic [size*data_size-1:0]      diff_to_all,
    input  logic [size*data_size-1:0]      diff_start,
    input  logic [size*data_size-1:0]      diff_dense,
    input  logic [size*data_size-1:0]      diff_cost,
    input  logic                           is_update,
    input  logic                           is_cost_layer,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [index_size-1:0]          w_layer_index_out,
    output logic [index_size-1:0]          w_row_index_out,
    output logic                           backprop_cost_out,
    output logic [size*data_size-1:0]      diff_to_all_out,
    output logic [size*data_size-1:0]      diff_start_out,
    output logic [size*data_size-1:0]      diff_dense_out,
    output logic [size*data_size-1:0]      diff_cost_out,
    output logic                           is_update_out,
    output logic                           is_cost_layer_out,
    output logic [$clog2(stages+1)-1:0]    occupancy
`ifdef DIFF_BACKPROP_PIPE_STALL_STATS_EN
    ,
    input  logic                           stall_clear,
    output logic [31:0]                    stall_count
`endif
);

    localparam int occ_w = $clog2(stages + 1);

    typedef struct packed {
        logic [index_size-1:0]     w_layer_index;
        logic [index_size-1:0]     w_row_index;
        logic                      backprop_cost;
        logic [size*data_size-1:0] diff_to_all;
        logic [size*data_size-1:0] diff_start;
        logic [size*data_size-1:0] diff_dense;
        logic [size*data_size-1:0] diff_cost;
        logic                      is_update;
        logic                      is_cost_layer;
    } bundle_t;

    bundle_t            in_bundle;
    bundle_t            data_q   [stages];
    bundle_t            pred_dat [stages];
    logic [stages-1:0]  valid_q;
    logic [stages-1:0]  valid_d;
    logic [stages-1:0]  pred_vld;
    logic [stages-1:0]  adv;
    logic [occ_w-1:0]   occ_d;

    assign in_bundle = '{w_layer_index: w_layer_index, w_row_index: w_row_index,
                         backprop_cost: backprop_cost, diff_to_all: diff_to_all,
                         diff_start: diff_start, diff_dense: diff_dense,
                         diff_cost: diff_cost, is_update: is_update,
                         is_cost_layer: is_cost_layer};

    // Advance enables, resolved from the output stage back towards the input so bubbles always fill.
    always_comb begin
        adv = '0;
        adv[stages-1] = out_ready || !valid_q[stages-1];
        for (int i = stages - 2; i >= 0; i--) begin
            adv[i] = !valid_q[i] || !valid_q[i+1] || adv[i+1];
        end
    end

    // Predecessor view of each stage: the input port feeds stage 0, stage i-1 feeds stage i.
    always_comb begin
        pred_vld    = '0;
        pred_vld[0] = in_valid;
        pred_dat[0] = in_bundle;
        for (int i = 1; i < stages; i++) begin
            pred_vld[i] = valid_q[i-1];
            pred_dat[i] = data_q[i-1];
        end
    end

    // Next valid bits and the count of valid stages after the edge; flush empties every stage.
    always_comb begin
        valid_d = valid_q;
        occ_d   = '0;
        for (int i = 0; i < stages; i++) begin
            if (flush) begin
                valid_d[i] = 1'b0;
            end else if (adv[i]) begin
                valid_d[i] = pred_vld[i];
            end
            occ_d = occ_d + occ_w'(valid_d[i]);
        end
    end

    // Stage registers: data loads only for a valid incoming beat and is left untouched by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= '0;
            occupancy <= '0;
            for (int i = 0; i < stages; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            occupancy <= occ_d;
            for (int i = 0; i < stages; i++) begin
                if (!flush && adv[i] && pred_vld[i]) begin
                    data_q[i] <= pred_dat[i];
                end
            end
        end
    end

    assign in_ready          = adv[0] && !flush && !reset;
    assign out_valid         = valid_q[stages-1];
    assign w_layer_index_out = data_q[stages-1].w_layer_index;
    assign w_row_index_out   = data_q[stages-1].w_row_index;
    assign backprop_cost_out = data_q[stages-1].backprop_cost;
    assign diff_to_all_out   = data_q[stages-1].diff_to_all;
    assign diff_start_out    = data_q[stages-1].diff_start;
    assign diff_dense_out    = data_q[stages-1].diff_dense;
    assign diff_cost_out     = data_q[stages-1].diff_cost;
    assign is_update_out     = data_q[stages-1].is_update;
    assign is_cost_layer_out = data_q[stages-1].is_cost_layer;

`ifdef DIFF_BACKPROP_PIPE_STALL_STATS_EN
    // Saturating count of output stall cycles; clear takes precedence over increment, flush does not clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_clear) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && stall_count != 32'hFFFF_FFFF) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_diff_backprop_pipe.sv
// Directed bench for diff_backprop_pipe with stages=3: reset, latency, stall/fill, bubble collapse,
// sustained full-rate transfer, flush and asynchronous reset; stall statistics when the macro is set.
module tb_diff_backprop_pipe;

    localparam int SIZE = 3;
    localparam int DW   = 16;
    localparam int IW   = 32;
    localparam int ST   = 3;
    localparam int VW   = SIZE * DW;
    localparam int BW   = 2 * IW + 1 + 4 * VW + 2;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [IW-1:0] w_layer_index, w_row_index, w_layer_index_out, w_row_index_out;
    logic          backprop_cost, is_update, is_cost_layer;
    logic          backprop_cost_out, is_update_out, is_cost_layer_out;
    logic [VW-1:0] diff_to_all, diff_start, diff_dense, diff_cost;
    logic [VW-1:0] diff_to_all_out, diff_start_out, diff_dense_out, diff_cost_out;
    logic [1:0]    occupancy;
`ifdef DIFF_BACKPROP_PIPE_STALL_STATS_EN
    logic          stall_clear;
    logic [31:0]   stall_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    diff_backprop_pipe #(.size(SIZE), .data_size(DW), .index_size(IW), .stages(ST)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .w_layer_index(w_layer_index), .w_row_index(w_row_index), .backprop_cost(backprop_cost),
        .diff_to_all(diff_to_all), .diff_start(diff_start), .diff_dense(diff_dense),
        .diff_cost(diff_cost), .is_update(is_update), .is_cost_layer(is_cost_layer),
        .out_valid(out_valid), .out_ready(out_ready),
        .w_layer_index_out(w_layer_index_out), .w_row_index_out(w_row_index_out),
        .backprop_cost_out(backprop_cost_out), .diff_to_all_out(diff_to_all_out),
        .diff_start_out(diff_start_out), .diff_dense_out(diff_dense_out),
        .diff_cost_out(diff_cost_out), .is_update_out(is_update_out),
        .is_cost_layer_out(is_cost_layer_out), .occupancy(occupancy)
`ifdef DIFF_BACKPROP_PIPE_STALL_STATS_EN
        , .stall_clear(stall_clear), .stall_count(stall_count)
`endif
    );

    // Bundle derived from a small tag so every field of every beat is distinct.
    function automatic logic [BW-1:0] beat(input int k);
        logic [31:0] kv;
        kv = k;
        return {IW'(k), IW'(k + 100), kv[0],
                {16'(k), 16'(k + 1), 16'(k + 2)} ^ 48'h1111_2222_3333,
                {16'(k + 7), 16'(k), 16'(k + 9)} ^ 48'hAAAA_5555_0F0F,
                {16'(k * 3), 16'(k * 5), 16'(k * 7)},
                {16'(k - 2), 16'(k - 3), 16'(k - 4)},
                kv[1], kv[2]};
    endfunction

    function automatic logic [BW-1:0] out_vec();
        return {w_layer_index_out, w_row_index_out, backprop_cost_out, diff_to_all_out,
                diff_start_out, diff_dense_out, diff_cost_out, is_update_out, is_cost_layer_out};
    endfunction

    task automatic drive(input int k, input logic v);
        {w_layer_index, w_row_index, backprop_cost, diff_to_all, diff_start,
         diff_dense, diff_cost, is_update, is_cost_layer} = beat(k);
        in_valid = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        vectors++; if (out_vec() !== BW'(0)) begin miscompares++; $display("FAIL reset_outputs got %h exp 0", out_vec()); end
        step();
        reset = 1'b0;
        step();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(5, 1'b1);
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
        step();
        drive(0, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            vectors++; if (occupancy !== 2'd1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL single_c%0d got occ %0d ov %b exp occ 1 ov 0", c, occupancy, out_valid); end
            step();
        end
        vectors++; if (out_valid !== 1'b1 || occupancy !== 2'd1) begin miscompares++; $display("FAIL single_c3 got ov %b occ %0d exp ov 1 occ 1", out_valid, occupancy); end
        vectors++; if (diff_cost_out !== 48'h0003_0002_0001) begin miscompares++; $display("FAIL single_diff_cost got %h exp 000300020001", diff_cost_out); end
        vectors++; if (w_layer_index_out !== 32'd5) begin miscompares++; $display("FAIL single_layer got %0d exp 5", w_layer_index_out); end
        vectors++; if (out_vec() !== beat(5)) begin miscompares++; $display("FAIL single_bundle got %h exp %h", out_vec(), beat(5)); end
        step();
        vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL single_pop got ov %b occ %0d exp ov 0 occ 0", out_valid, occupancy); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive(10 + n, 1'b1);
            #1;
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_accept%0d got %b exp 1", n, in_ready); end
            step();
        end
        drive(13, 1'b1);
        #1;
        vectors++; if (in_ready !== 1'b0 || occupancy !== 2'd3) begin miscompares++; $display("FAIL stall_full got rdy %b occ %0d exp rdy 0 occ 3", in_ready, occupancy); end
        vectors++; if (out_valid !== 1'b1 || out_vec() !== beat(10)) begin miscompares++; $display("FAIL stall_head got ov %b %h exp ov 1 %h", out_valid, out_vec(), beat(10)); end
        step();
        vectors++; if (occupancy !== 2'd3 || out_vec() !== beat(10)) begin miscompares++; $display("FAIL stall_hold got occ %0d %h exp occ 3 %h", occupancy, out_vec(), beat(10)); end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_rdy got %b exp 1", in_ready); end
        for (int n = 0; n < 4; n++) begin
            vectors++; if (out_valid !== 1'b1 || out_vec() !== beat(10 + n)) begin miscompares++; $display("FAIL stall_drain%0d got ov %b %h exp ov 1 %h", n, out_valid, out_vec(), beat(10 + n)); end
            step();
            drive(0, 1'b0);
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        drive(20, 1'b1);
        step();
        drive(0, 1'b0);
        step();
        drive(21, 1'b1);
        step();
        drive(0, 1'b0);
        vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("FAIL bubble_gap_occ got %0d exp 2", occupancy); end
        step();
        step();
        vectors++; if (occupancy !== 2'd2 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bubble_collapse got occ %0d ov %b exp occ 2 ov 1", occupancy, out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bubble_in_ready got %b exp 1", in_ready); end
        vectors++; if (out_vec() !== beat(20)) begin miscompares++; $display("FAIL bubble_first got %h exp %h", out_vec(), beat(20)); end
        out_ready = 1'b1;
        step();
        vectors++; if (out_valid !== 1'b1 || out_vec() !== beat(21)) begin miscompares++; $display("FAIL bubble_second got ov %b %h exp ov 1 %h", out_valid, out_vec(), beat(21)); end
        step();
        vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL bubble_empty got ov %b occ %0d exp ov 0 occ 0", out_valid, occupancy); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive(30 + n, 1'b1);
            step();
        end
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            drive(33 + n, 1'b1);
            #1;
            vectors++; if (occupancy !== 2'd3 || in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_occ%0d got occ %0d rdy %b exp occ 3 rdy 1", n, occupancy, in_ready); end
            vectors++; if (out_valid !== 1'b1 || out_vec() !== beat(30 + n)) begin miscompares++; $display("FAIL b2b_beat%0d got ov %b %h exp ov 1 %h", n, out_valid, out_vec(), beat(30 + n)); end
            step();
        end
        drive(0, 1'b0);
        vectors++; if (occupancy !== 2'd3) begin miscompares++; $display("FAIL b2b_final_occ got %0d exp 3", occupancy); end
        for (int n = 0; n < 3; n++) begin
            vectors++; if (out_valid !== 1'b1 || out_vec() !== beat(40 + n)) begin miscompares++; $display("FAIL b2b_tail%0d got ov %b %h exp ov 1 %h", n, out_valid, out_vec(), beat(40 + n)); end
            step();
        end
        vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL b2b_empty got ov %b occ %0d exp ov 0 occ 0", out_valid, occupancy); end
    endtask

    task automatic test_flush_and_reset();
        out_ready = 1'b0;
        drive(50, 1'b1);
        step();
        drive(51, 1'b1);
        step();
        drive(0, 1'b0);
        step();
        vectors++; if (occupancy !== 2'd2 || out_valid !== 1'b1) begin miscompares++; $display("FAIL flush_pre got occ %0d ov %b exp occ 2 ov 1", occupancy, out_valid); end
        flush = 1'b1;
        drive(52, 1'b1);
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        step();
        flush = 1'b0;
        drive(0, 1'b0);
        #1;
        vectors++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_clear got occ %0d ov %b exp occ 0 ov 0", occupancy, out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_after_rdy got %b exp 1", in_ready); end
        vectors++; if (out_vec() !== beat(50)) begin miscompares++; $display("FAIL flush_data_kept got %h exp %h", out_vec(), beat(50)); end
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) step();
        vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL flush_dropped got ov %b occ %0d exp ov 0 occ 0", out_valid, occupancy); end

        out_ready = 1'b0;
        drive(60, 1'b1);
        step();
        drive(61, 1'b1);
        step();
        drive(0, 1'b0);
        step();
        vectors++; if (out_valid !== 1'b1 || out_vec() !== beat(60)) begin miscompares++; $display("FAIL rst_pre got ov %b %h exp ov 1 %h", out_valid, out_vec(), beat(60)); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL rst_async got ov %b occ %0d exp ov 0 occ 0", out_valid, occupancy); end
        vectors++; if (out_vec() !== BW'(0) || in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_async_data got %h rdy %b exp 0 rdy 0", out_vec(), in_ready); end
        step();
        reset = 1'b0;
        step();
    endtask

`ifdef DIFF_BACKPROP_PIPE_STALL_STATS_EN
    task automatic test_stall_stats();
        out_ready = 1'b0;
        vectors++; if (stall_count !== 32'd0) begin miscompares++; $display("FAIL stats_reset got %0d exp 0", stall_count); end
        drive(70, 1'b1);
        step();
        drive(0, 1'b0);
        step();
        step();
        vectors++; if (out_valid !== 1'b1 || stall_count !== 32'd0) begin miscompares++; $display("FAIL stats_start got ov %b cnt %0d exp ov 1 cnt 0", out_valid, stall_count); end
        for (int n = 0; n < 7; n++) step();
        vectors++; if (stall_count !== 32'd7) begin miscompares++; $display("FAIL stats_seven got %0d exp 7", stall_count); end
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        vectors++; if (stall_count !== 32'd7 || out_valid !== 1'b0) begin miscompares++; $display("FAIL stats_flush got cnt %0d ov %b exp cnt 7 ov 0", stall_count, out_valid); end
        stall_clear = 1'b1;
        step();
        stall_clear = 1'b0;
        vectors++; if (stall_count !== 32'd0) begin miscompares++; $display("FAIL stats_clear got %0d exp 0", stall_count); end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
`ifdef DIFF_BACKPROP_PIPE_STALL_STATS_EN
        stall_clear = 1'b0;
`endif
        drive(0, 1'b0);
        test_reset();
        test_single();
        test_stall();
        test_bubble();
        test_back_to_back();
        test_flush_and_reset();
`ifdef DIFF_BACKPROP_PIPE_STALL_STATS_EN
        test_stall_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
